// File: rtl/beta_pkg.sv
// Shared constants and helpers for the beta operand-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: DATA_W, REG_ADDR_W, OPCODE_W, LIT_W, NUM_REGS, ZERO_REG, sext_lit().
package beta_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OPCODE_W   = 6;
  localparam int LIT_W      = 16;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

  // Sign-extend the 16-bit instruction literal to a full operand.
  function automatic logic [DATA_W-1:0] sext_lit(input logic [LIT_W-1:0] lit);
    return {{(DATA_W-LIT_W){lit[LIT_W-1]}}, lit};
  endfunction

endpackage

// File: rtl/beta_regfile.sv
// 32-entry register file, 2 async read ports, 1 sync write port; ZERO_REG reads 0 and ignores writes.
// Latency: reads combinational; a write becomes visible to reads the cycle after its edge.
// Backpressure: none; a write is taken at every edge where wr_en=1 and rst_n=1.
// Ports: clk, rst_n (sync, active-low, clears all entries), wr_en/wr_addr/wr_data,
//        rd_addr0 -> rd_data0, rd_addr1 -> rd_data1.
module beta_regfile #(
  parameter int                                DATA_W   = beta_pkg::DATA_W,
  parameter logic [beta_pkg::REG_ADDR_W-1:0]   ZERO_REG = beta_pkg::ZERO_REG
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [beta_pkg::REG_ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic [beta_pkg::REG_ADDR_W-1:0]   rd_addr0,
  output logic [DATA_W-1:0]                 rd_data0,
  input  logic [beta_pkg::REG_ADDR_W-1:0]   rd_addr1,
  output logic [DATA_W-1:0]                 rd_data1
);
  import beta_pkg::*;

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != ZERO_REG)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // The zero register is forced at the read mux so its storage never matters.
  assign rd_data0 = (rd_addr0 == ZERO_REG) ? '0 : regs[rd_addr0];
  assign rd_data1 = (rd_addr1 == ZERO_REG) ? '0 : regs[rd_addr1];

endmodule

// File: rtl/beta_operand_stage.sv
// Beta operand fetch: reads R[ra] and R[rb]/sext(lit) into a one-deep valid/ready output register.
// Latency: one cycle from accept to out_valid; one instruction per cycle when out_ready stays high.
// Backpressure: in_ready = !out_valid || out_ready; outputs hold while stalled.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, in_ra, in_rb, in_lit, in_bsel, in_opcode,
//        in_rc; wb_en/wb_addr/wb_data write-back; out_valid/out_ready, out_data0/1, out_opcode, out_rc.
// Option: define BETA_OPERAND_BYPASS_EN to forward a same-cycle write-back into the captured operands.
module beta_operand_stage #(
  parameter int                                DATA_W   = beta_pkg::DATA_W,
  parameter logic [beta_pkg::REG_ADDR_W-1:0]   ZERO_REG = beta_pkg::ZERO_REG
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [beta_pkg::REG_ADDR_W-1:0]   in_ra,
  input  logic [beta_pkg::REG_ADDR_W-1:0]   in_rb,
  input  logic [beta_pkg::LIT_W-1:0]        in_lit,
  input  logic                              in_bsel,
  input  logic [beta_pkg::OPCODE_W-1:0]     in_opcode,
  input  logic [beta_pkg::REG_ADDR_W-1:0]   in_rc,
  input  logic                              wb_en,
  input  logic [beta_pkg::REG_ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]                 wb_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data0,
  output logic [DATA_W-1:0]                 out_data1,
  output logic [beta_pkg::OPCODE_W-1:0]     out_opcode,
  output logic [beta_pkg::REG_ADDR_W-1:0]   out_rc
);
  import beta_pkg::*;

  logic [DATA_W-1:0] rf_data0;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] ra_val;
  logic [DATA_W-1:0] rb_val;
  logic [DATA_W-1:0] lit_ext;
  logic [DATA_W-1:0] opnd1;
  logic              accept;

  beta_regfile #(
    .DATA_W   (DATA_W),
    .ZERO_REG (ZERO_REG)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wb_en),
    .wr_addr  (wb_addr),
    .wr_data  (wb_data),
    .rd_addr0 (in_ra),
    .rd_data0 (rf_data0),
    .rd_addr1 (in_rb),
    .rd_data1 (rf_data1)
  );

`ifdef BETA_OPERAND_BYPASS_EN
  // A write landing on this edge would otherwise be missed by the capture.
  assign ra_val = (wb_en && (wb_addr == in_ra) && (in_ra != ZERO_REG)) ? wb_data : rf_data0;
  assign rb_val = (wb_en && (wb_addr == in_rb) && (in_rb != ZERO_REG)) ? wb_data : rf_data1;
`else
  // Capture the pre-write value; a same-edge write is seen by later instructions only.
  assign ra_val = rf_data0;
  assign rb_val = rf_data1;
`endif

  assign lit_ext  = sext_lit(in_lit);
  assign opnd1    = in_bsel ? lit_ext : rb_val;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data0  <= '0;
      out_data1  <= '0;
      out_opcode <= '0;
      out_rc     <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data0  <= ra_val;
      out_data1  <= opnd1;
      out_opcode <= in_opcode;
      out_rc     <= in_rc;
    end else if (out_ready) begin
      // Drained with nothing new: only the valid flag drops, data stays put.
      out_valid  <= 1'b0;
    end
  end

endmodule
